// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data memory responder with a
// valid/ready request channel and a valid/ready response channel.
// A request is captured in IDLE, waits LATENCY cycles, then the store is
// committed or the load data is registered as the FSM enters RESP.
// Misaligned or out-of-range addresses complete with resp_err=1.
// Optional feature: define DMEM_BYTE_STROBE_EN to add a req_wstrb[7:0]
// byte-enable input for stores.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [7:0]  req_wstrb,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [63:0] MEM_BYTES = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [3:0]  LAT_LOAD  = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [3:0]  r_cnt;
  logic [3:0]  w_nextCnt;

  logic        r_write;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [7:0]  r_wstrb;

  logic [63:0] r_mem [DEPTH_WORDS];

  logic        r_respValid;
  logic [63:0] r_respRdata;
  logic        r_respErr;

  logic        w_accept;
  logic        w_enterResp;
  logic        w_respDone;
  logic        w_write;
  logic [63:0] w_addr;
  logic [63:0] w_wdata;
  logic [7:0]  w_wstrb;
  logic [7:0]  w_reqWstrb;
  logic [AW-1:0] w_idx;
  logic        w_err;

`ifdef DMEM_BYTE_STROBE_EN
  assign w_reqWstrb = req_wstrb;
`else
  assign w_reqWstrb = 8'hFF;
`endif

  // With LATENCY=0 RESP is entered on the accept edge itself, so the
  // request fields come straight from the inputs while still in IDLE.
  assign w_write = (r_state == IDLE) ? req_write  : r_write;
  assign w_addr  = (r_state == IDLE) ? req_addr   : r_addr;
  assign w_wdata = (r_state == IDLE) ? req_wdata  : r_wdata;
  assign w_wstrb = (r_state == IDLE) ? w_reqWstrb : r_wstrb;

  assign w_idx = w_addr[AW+2:3];
  assign w_err = (w_addr[2:0] != 3'b000) || (w_addr >= MEM_BYTES);

  // Next-state, counter and handshake decode for the request/response FSM.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_accept    = 1'b0;
    w_enterResp = 1'b0;
    w_respDone  = 1'b0;
    req_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = !resetl;
        if (req_valid && !resetl) begin
          w_accept = 1'b1;
          if (LAT_LOAD == 4'd0) begin
            w_nextState = RESP;
            w_enterResp = 1'b1;
          end else begin
            w_nextState = WAIT;
            w_nextCnt   = LAT_LOAD;
          end
        end
      end
      WAIT: begin
        w_nextCnt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_nextState = RESP;
          w_enterResp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_nextState = IDLE;
          w_respDone  = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State and wait-counter registers; reset abandons any transaction.
  always_ff @(posedge CLK) begin
    if (resetl) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // Request capture at the accept edge.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_wstrb <= w_reqWstrb;
    end
  end

  // Response registers: loaded on entering RESP, cleared on handshake.
  always_ff @(posedge CLK) begin
    if (resetl) begin
      r_respValid <= 1'b0;
      r_respRdata <= 64'd0;
      r_respErr   <= 1'b0;
    end else if (w_enterResp) begin
      r_respValid <= 1'b1;
      r_respErr   <= w_err;
      r_respRdata <= (w_write || w_err) ? 64'd0 : r_mem[w_idx];
    end else if (w_respDone) begin
      r_respValid <= 1'b0;
      r_respRdata <= 64'd0;
      r_respErr   <= 1'b0;
    end
  end

  // Storage write on entering RESP; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!resetl && w_enterResp && w_write && !w_err) begin
      for (int b = 0; b < 8; b++) begin
        if (w_wstrb[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign resp_valid = r_respValid;
  assign resp_rdata = r_respRdata;
  assign resp_err   = r_respErr;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: randomized and directed transactions
// compared against a word-array reference model; a second instance with
// LATENCY=0 exercises back-to-back throughput.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        CLK;
  logic        resetl;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
`ifdef DMEM_BYTE_STROBE_EN
  logic [7:0]  req_wstrb;
  logic [7:0]  wstrb0;
`endif

  logic        v0;
  logic        rdy0;
  logic        w0;
  logic [63:0] a0;
  logic [63:0] d0;
  logic        rv0;
  logic        rr0;
  logic [63:0] rd0;
  logic        re0;

  int checks = 0;
  int errors = 0;

  logic [63:0] model [DEPTH];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .resetl(resetl),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb(req_wstrb),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .CLK(CLK), .resetl(resetl),
    .req_valid(v0), .req_ready(rdy0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0),
`ifdef DMEM_BYTE_STROBE_EN
    .req_wstrb(wstrb0),
`endif
    .resp_valid(rv0), .resp_ready(rr0),
    .resp_rdata(rd0), .resp_err(re0)
  );

  // Free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on the main instance, checked against the model.
  task automatic applyStimulus(input logic w, input logic [63:0] a, input logic [63:0] d,
                               input logic [7:0] s, input int hold);
    int          n;
    int          idx;
    logic        expErr;
    logic [63:0] expData;
    expErr  = (a % 64'd8 != 64'd0) || (a >= 64'(DEPTH) * 64'd8);
    idx     = expErr ? 0 : int'(a / 64'd8);
    expData = (w || expErr) ? 64'd0 : model[idx];
    @(negedge CLK);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb = s;
`endif
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!req_ready) begin
      checkOutput("acceptTimeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = {$urandom, $urandom};
    req_wdata = {$urandom, $urandom};
    n = 0;
    while (!resp_valid && n < 50) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("latency", 64'(n), 64'(LAT));
    if (!resp_valid) return;
    checkOutput("rdata", resp_rdata, expData);
    checkOutput("err", 64'(resp_err), 64'(expErr));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 64'h0;
      req_wdata = ~model[0];
      @(negedge CLK);
      checkOutput("holdValid", 64'(resp_valid), 64'd1);
      checkOutput("holdRdata", resp_rdata, expData);
      checkOutput("holdErr", 64'(resp_err), 64'(expErr));
      checkOutput("holdReqReady", 64'(req_ready), 64'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge CLK);
    resp_ready = 1'b0;
    checkOutput("clrValid", 64'(resp_valid), 64'd0);
    checkOutput("clrRdata", resp_rdata, 64'd0);
    checkOutput("clrErr", 64'(resp_err), 64'd0);
    checkOutput("readyAfter", 64'(req_ready), 64'd1);
    if (w && !expErr) begin
      for (int b = 0; b < 8; b++) begin
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  function automatic logic [63:0] randAddr();
    logic [63:0] a;
    case ($urandom_range(0, 9))
      0:       a = 64'(8 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 7));
      1:       a = 64'(DEPTH) * 64'd8 + 64'(8 * $urandom_range(0, 100));
      2:       a = {1'b1, 31'($urandom), 29'($urandom), 3'b000};
      default: a = 64'(8 * $urandom_range(0, DEPTH - 1));
    endcase
    return a;
  endfunction

  // Main stimulus sequence.
  initial begin
    int acc;
    int last;
    logic [7:0] s;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0;
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb = 8'hFF;
    wstrb0    = 8'hFF;
`endif
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0; rr0 = 1'b0;

    resetl = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("rstReqReady", 64'(req_ready), 64'd0);
    checkOutput("rstValid", 64'(resp_valid), 64'd0);
    checkOutput("rstRdata", resp_rdata, 64'd0);
    checkOutput("rstErr", 64'(resp_err), 64'd0);
    resetl = 1'b0;
    #1;
    checkOutput("postRstReady", 64'(req_ready), 64'd1);

    // Fill storage so every later load has a known expected value.
    for (int k = 0; k < DEPTH; k++) begin
      applyStimulus(1'b1, 64'(8 * k), {$urandom, $urandom}, 8'hFF, 0);
    end

    applyStimulus(1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 0);
    applyStimulus(1'b0, 64'h10, 64'h0, 8'hFF, 0);
    checkOutput("model0x10", model[2], 64'hDEADBEEF_CAFEF00D);

    applyStimulus(1'b0, 64'h0C, 64'h0, 8'hFF, 0);
    applyStimulus(1'b0, 64'h800, 64'h0, 8'hFF, 0);
    applyStimulus(1'b1, 64'h0C, 64'h1234_5678_9ABC_DEF0, 8'hFF, 0);
    applyStimulus(1'b1, 64'h800, 64'h1111_2222_3333_4444, 8'hFF, 0);
    applyStimulus(1'b0, 64'h08, 64'h0, 8'hFF, 0);
    applyStimulus(1'b0, 64'h00, 64'h0, 8'hFF, 0);

    applyStimulus(1'b0, 64'h10, 64'h0, 8'hFF, 5);
    applyStimulus(1'b0, 64'h00, 64'h0, 8'hFF, 0);

    // Reset while a store to 0x20 waits: the store must be dropped.
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h20; req_wdata = ~model[4];
`ifdef DMEM_BYTE_STROBE_EN
    req_wstrb = 8'hFF;
`endif
    #1;
    checkOutput("rstTestReady", 64'(req_ready), 64'd1);
    @(posedge CLK);
    @(negedge CLK);
    req_valid = 1'b0;
    resetl = 1'b1;
    @(negedge CLK);
    checkOutput("midRstReqReady", 64'(req_ready), 64'd0);
    checkOutput("midRstValid", 64'(resp_valid), 64'd0);
    checkOutput("midRstRdata", resp_rdata, 64'd0);
    checkOutput("midRstErr", 64'(resp_err), 64'd0);
    @(negedge CLK);
    resetl = 1'b0;
    #1;
    checkOutput("midPostRstReady", 64'(req_ready), 64'd1);
    applyStimulus(1'b0, 64'h20, 64'h0, 8'hFF, 0);

`ifdef DMEM_BYTE_STROBE_EN
    applyStimulus(1'b1, 64'h0, 64'h0, 8'hFF, 0);
    applyStimulus(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
    applyStimulus(1'b0, 64'h0, 64'h0, 8'hFF, 0);
    checkOutput("strobeModel", model[0], 64'h00000000_FFFFFFFF);
`endif

    for (int t = 0; t < 80; t++) begin
`ifdef DMEM_BYTE_STROBE_EN
      s = 8'($urandom);
`else
      s = 8'hFF;
`endif
      applyStimulus(1'($urandom), randAddr(), {$urandom, $urandom}, s, $urandom_range(0, 2));
    end

    // LATENCY=0 instance: request and response held ready -> accept every 2 cycles.
    @(negedge CLK);
    v0 = 1'b1; w0 = 1'b1; a0 = 64'h8; d0 = 64'hA5A5_0000_5A5A_FFFF; rr0 = 1'b1;
    #1;
    acc  = 0;
    last = -1;
    for (int i = 0; i < 20; i++) begin
      if (rdy0) begin
        acc++;
        if (last >= 0) checkOutput("lat0Gap", 64'(i - last), 64'd2);
        last = i;
      end else begin
        checkOutput("lat0RespValid", 64'(rv0), 64'd1);
      end
      @(negedge CLK);
      #1;
    end
    checkOutput("lat0Accepts", 64'(acc), 64'd10);
    v0 = 1'b0;
    repeat (3) @(negedge CLK);
    checkOutput("lat0Drained", 64'(rv0), 64'd0);
    rr0 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
